// File: rtl/snn_seq_pkg.sv
// Shared types and defaults for the SNN timestep sequencer.
// Holds the sequencer state encoding and the spike-row popcount helper.
package snn_seq_pkg;
   localparam int SEQ_F  = 48;
   localparam int SEQ_N  = 96;
   localparam int SEQ_AW = $clog2(SEQ_F * SEQ_N);
   localparam int SEQ_EW = 16;
   localparam int SEQ_CW = $clog2(SEQ_N) + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LOAD, S_EVAL, S_EMIT, S_LEARN, S_GAP, S_DUMP, S_FIN
   } seq_state_t;

   function automatic logic [SEQ_CW-1:0] popcount_n(input logic [SEQ_N-1:0] row);
      logic [SEQ_CW-1:0] c;
      c = '0;
      for (int i = 0; i < SEQ_N; i++) c = c + SEQ_CW'(row[i]);
      return c;
   endfunction
endpackage

// File: rtl/snn_seq_dump.sv
// Weight dump: walks readback addresses 0..TOT-1 and turns the 1-cycle-latency
// readback port into a valid/ready stream with no skipped or repeated words.
module snn_seq_dump
   import snn_seq_pkg::*;
#(
   parameter int AW  = SEQ_AW,
   parameter int TOT = SEQ_F * SEQ_N
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_go,
   input  logic [15:0]   i_rb_data,
   input  logic          i_w_ready,
   output logic [AW-1:0] o_rb_addr,
   output logic          o_w_valid,
   output logic [AW-1:0] o_w_addr,
   output logic [15:0]   o_w_data,
   output logic          o_fin
);
   logic          r_act;
   logic [AW:0]   r_nxt;
   logic [AW-1:0] r_ra;
   logic          r_rv;
   logic          r_wv;
   logic [AW-1:0] r_waddr;
   logic [15:0]   r_wdata;

   logic          w_free, w_stall, w_more, w_req, w_take, w_fin;
   logic [AW-1:0] w_rb_addr;

   // rb_data always reflects r_ra; on a stall the same address is re-presented
   // so the word waiting on rb_data stays valid until the output frees up.
   assign w_free    = !r_wv || i_w_ready;
   assign w_stall   = r_rv && !w_free;
   assign w_more    = r_act && (r_nxt < (AW+1)'(TOT));
   assign w_req     = !w_stall && w_more;
   assign w_take    = r_rv && w_free;
   assign w_rb_addr = w_stall ? r_ra : (w_req ? r_nxt[AW-1:0] : '0);
   assign w_fin     = r_wv && i_w_ready && (r_waddr == AW'(TOT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_act   <= 1'b0;
         r_nxt   <= '0;
         r_ra    <= '0;
         r_rv    <= 1'b0;
         r_wv    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         if (i_go) begin
            r_act <= 1'b1;
            r_nxt <= '0;
         end else begin
            if (w_req) r_nxt <= r_nxt + 1'b1;
            if (w_fin) r_act <= 1'b0;
         end
         r_rv <= w_stall | w_req;
         r_ra <= w_rb_addr;
         if (w_take) begin
            r_wv    <= 1'b1;
            r_wdata <= i_rb_data;
            r_waddr <= r_ra;
         end else if (i_w_ready) begin
            r_wv <= 1'b0;
         end
      end
   end

   assign o_rb_addr = w_rb_addr;
   assign o_w_valid = r_wv;
   assign o_w_addr  = r_waddr;
   assign o_w_data  = r_wdata;
   assign o_fin     = w_fin;
endmodule

// File: rtl/snn_step_sequencer.sv
// Timestep controller for snn_core: fetch event row, evaluate, emit spikes,
// optional STDP scan and weight dump. SNN_SEQ_SPKCNT_EN adds spike statistics.
module snn_step_sequencer
   import snn_seq_pkg::*;
#(
   parameter int F    = SEQ_F,
   parameter int N    = SEQ_N,
   parameter int AW   = $clog2(F * N),
   parameter int EW   = SEQ_EW,
   parameter int SCAN = F * N
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [EW:0]   cfg_T,
   input  logic          cfg_learn,
   output logic          busy,
   output logic          done,
   output logic          ev_rd_en,
   output logic [EW-1:0] ev_addr,
   input  logic [F-1:0]  ev_rdata,
   output logic [F-1:0]  event_vec,
   input  logic [N-1:0]  spikes_vec,
   output logic          stdp_enable,
   output logic [F-1:0]  stdp_pre_bits,
   output logic [N-1:0]  stdp_post_bits,
   output logic          spk_valid,
   input  logic          spk_ready,
   output logic [N-1:0]  spk_data,
   output logic [EW-1:0] spk_t,
   output logic [AW-1:0] rb_addr,
   input  logic [15:0]   rb_data,
   output logic          w_valid,
   input  logic          w_ready,
   output logic [AW-1:0] w_addr,
   output logic [15:0]   w_data,
`ifdef SNN_SEQ_SPKCNT_EN
   output logic [31:0]   spk_total,
   output logic [$clog2(N):0] spk_max_row,
`endif
   output seq_state_t    dbg_state
);
   localparam int SW = $clog2(SCAN) + 1;

   seq_state_t    r_state, w_next;
   logic [EW:0]   r_t, r_T, w_t_inc;
   logic          r_learn, r_cap;
   logic [F-1:0]  r_event;
   logic [N-1:0]  r_spk;
   logic [EW-1:0] r_spk_t;
   logic [SW-1:0] r_scan;
   logic          w_step_done, w_dump_go, w_dump_fin;
   seq_state_t    w_after;

   assign w_t_inc = r_t + 1'b1;
   assign w_after = (w_t_inc < r_T) ? S_FETCH : (r_learn ? S_DUMP : S_FIN);

   always_comb begin
      w_next      = r_state;
      w_step_done = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_next = (cfg_T == '0) ? S_FIN : S_FETCH;
         S_FETCH: w_next = S_LOAD;
         S_LOAD:  w_next = S_EVAL;
         S_EVAL:  w_next = S_EMIT;
         S_EMIT: begin
            if (r_cap && spk_ready) begin
               if (r_learn) begin
                  w_next = S_LEARN;
               end else begin
                  w_step_done = 1'b1;
                  w_next      = w_after;
               end
            end
         end
         S_LEARN: if (r_scan == SW'(SCAN - 1)) w_next = S_GAP;
         S_GAP: begin
            w_step_done = 1'b1;
            w_next      = w_after;
         end
         S_DUMP:  if (w_dump_fin) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_dump_go = (w_next == S_DUMP) && (r_state != S_DUMP);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_t     <= '0;
         r_T     <= '0;
         r_learn <= 1'b0;
         r_cap   <= 1'b0;
         r_event <= '0;
         r_spk   <= '0;
         r_spk_t <= '0;
         r_scan  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && start) begin
            r_T     <= cfg_T;
            r_learn <= cfg_learn;
            r_t     <= '0;
         end
         if (w_step_done) r_t <= w_t_inc;
         if (r_state == S_LOAD) r_event <= ev_rdata;
         // First EMIT cycle: spikes_vec is now two edges past the event_vec update.
         if (r_state == S_EMIT && !r_cap) begin
            r_spk   <= spikes_vec;
            r_spk_t <= r_t[EW-1:0];
            r_cap   <= 1'b1;
         end else if (r_state == S_EMIT && spk_ready) begin
            r_cap <= 1'b0;
         end
         r_scan <= (r_state == S_LEARN) ? r_scan + 1'b1 : '0;
      end
   end

`ifdef SNN_SEQ_SPKCNT_EN
   logic [$clog2(N):0] w_pop;
   logic [31:0]        r_total;
   logic [$clog2(N):0] r_max;
   assign w_pop = popcount_n(spikes_vec);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_total <= '0;
         r_max   <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_total <= '0;
         r_max   <= '0;
      end else if (r_state == S_EMIT && !r_cap) begin
         r_total <= r_total + 32'(w_pop);
         if (w_pop > r_max) r_max <= w_pop;
      end
   end
   assign spk_total   = r_total;
   assign spk_max_row = r_max;
`endif

   snn_seq_dump #(.AW(AW), .TOT(F * N)) u_dump (
      .clk       (clk),
      .rst       (rst),
      .i_go      (w_dump_go),
      .i_rb_data (rb_data),
      .i_w_ready (w_ready),
      .o_rb_addr (rb_addr),
      .o_w_valid (w_valid),
      .o_w_addr  (w_addr),
      .o_w_data  (w_data),
      .o_fin     (w_dump_fin)
   );

   assign busy           = (r_state != S_IDLE);
   assign done           = (r_state == S_FIN);
   assign ev_rd_en       = (r_state == S_FETCH);
   assign ev_addr        = r_t[EW-1:0];
   assign event_vec      = r_event;
   assign stdp_enable    = (r_state == S_LEARN);
   assign stdp_pre_bits  = (r_state == S_LEARN) ? r_event : '0;
   assign stdp_post_bits = (r_state == S_LEARN) ? r_spk : '0;
   assign spk_valid      = (r_state == S_EMIT) && r_cap;
   assign spk_data       = r_spk;
   assign spk_t          = r_spk_t;
   assign dbg_state      = r_state;
endmodule

// File: tb/tb_snn_step_sequencer.sv
// Directed bench for snn_step_sequencer with event-RAM, core and readback models.
module tb_snn_step_sequencer;
   import snn_seq_pkg::*;
   localparam int F = 48, N = 96, AW = 13, EW = 16, TOT = F * N;

   logic clk = 0, rst = 1, start = 0, cfg_learn = 0;
   logic [EW:0] cfg_T = '0;
   logic busy, done, ev_rd_en, stdp_enable, spk_valid, w_valid;
   logic spk_ready = 1, w_ready = 1;
   logic [EW-1:0] ev_addr, spk_t;
   logic [F-1:0] ev_rdata = '0, event_vec, stdp_pre_bits;
   logic [N-1:0] spikes_vec = '0, stdp_post_bits, spk_data;
   logic [AW-1:0] rb_addr, w_addr;
   logic [15:0] rb_data = '0, w_data;
   seq_state_t dbg_state;
`ifdef SNN_SEQ_SPKCNT_EN
   logic [31:0] spk_total;
   logic [$clog2(N):0] spk_max_row;
`endif

   snn_step_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .cfg_T(cfg_T), .cfg_learn(cfg_learn),
      .busy(busy), .done(done), .ev_rd_en(ev_rd_en), .ev_addr(ev_addr),
      .ev_rdata(ev_rdata), .event_vec(event_vec), .spikes_vec(spikes_vec),
      .stdp_enable(stdp_enable), .stdp_pre_bits(stdp_pre_bits),
      .stdp_post_bits(stdp_post_bits), .spk_valid(spk_valid), .spk_ready(spk_ready),
      .spk_data(spk_data), .spk_t(spk_t), .rb_addr(rb_addr), .rb_data(rb_data),
      .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
`ifdef SNN_SEQ_SPKCNT_EN
      .spk_total(spk_total), .spk_max_row(spk_max_row),
`endif
      .dbg_state(dbg_state)
   );

   // ---- clock / reset ----
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---- external models ----
   function automatic logic [F-1:0] ram_row(input int i);
      case (i)
         0: return 48'h1;
         1: return 48'h2;
         2: return 48'h4;
         default: return 48'hABCD_EF01_2345;
      endcase
   endfunction
   function automatic logic [15:0] wgt(input int a);
      return 16'(a * 37 + 5) ^ 16'h5A5A;
   endfunction

   always @(posedge clk) begin
      if (ev_rd_en) ev_rdata <= ram_row(int'(ev_addr));
      spikes_vec <= {event_vec, event_vec};
      rb_data    <= wgt(int'(rb_addr));
   end

   // w_ready pattern 1,0,0,1 when wtog is set
   logic wtog = 0;
   initial begin
      int k = 0;
      logic pat [4];
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
      forever begin
         @(posedge clk); #1;
         if (wtog) begin w_ready = pat[k]; k = (k + 1) % 4; end
         else w_ready = 1;
      end
   end

   // ---- monitors (counters clear on each accepted start) ----
   int spk_n, spk_bad, stdp_n, stdp_bad, fetch_n, w_n, w_bad, done_n, done_cyc, last_ev;
   always @(negedge clk) begin
      if (start && !busy && !rst) begin
         spk_n = 0; spk_bad = 0; stdp_n = 0; stdp_bad = 0; fetch_n = 0;
         w_n = 0; w_bad = 0; done_n = 0; done_cyc = 0; last_ev = cyc;
      end
      if (ev_rd_en) fetch_n++;
      if (spk_valid && spk_ready) begin
         if (int'(spk_t) != spk_n || spk_data !== {ram_row(spk_n), ram_row(spk_n)}) spk_bad++;
         spk_n++;
         last_ev = cyc;
      end
      if (stdp_enable) begin
         if (stdp_pre_bits !== ram_row(spk_n - 1) ||
             stdp_post_bits !== {ram_row(spk_n - 1), ram_row(spk_n - 1)}) stdp_bad++;
         stdp_n++;
      end
      if (w_valid && w_ready) begin
         if (int'(w_addr) != w_n || w_data !== wgt(w_n)) w_bad++;
         w_n++;
         last_ev = cyc;
      end
      if (done) begin done_n++; done_cyc = cyc; end
   end

   // ---- scoreboard ----
   int n_checks = 0, n_fail = 0;
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int T; bit learn; bit wt; bit stall;
      int exp_beats; int exp_stdp; int exp_fetch; int exp_w;
   } vec_t;

   task automatic pulse_start(input int T, input bit learn);
      @(posedge clk); #1;
      cfg_T = (EW+1)'(T); cfg_learn = learn; start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic run(input vec_t v);
      int stall_bad = 0, stall_fetch = 0;
      wtog = v.wt;
      pulse_start(v.T, v.learn);
      if (v.T > 0) begin
         // Ignored start with different config while busy
         @(posedge clk); #1;
         cfg_T = 7; cfg_learn = ~v.learn; start = 1;
         @(posedge clk); #1;
         start = 0;
      end
      fork
         begin
            for (int k = 0; k < 30000 && done_n == 0; k++) @(negedge clk);
         end
         if (v.stall) begin
            logic [N-1:0] d0; logic [EW-1:0] t0; logic [F-1:0] e0;
            bit seen = 0;
            for (int k = 0; k < 2000 && !seen; k++) begin
               @(posedge clk); #1;
               if (spk_valid && spk_t == 1) seen = 1;
            end
            if (!seen) stall_bad++;
            spk_ready = 0;
            d0 = spk_data; t0 = spk_t; e0 = event_vec;
            repeat (10) begin
               @(negedge clk);
               if (spk_data !== d0 || spk_t !== t0 || event_vec !== e0 ||
                   event_vec !== ram_row(1) || !spk_valid) stall_bad++;
               if (ev_rd_en) stall_fetch++;
            end
            @(posedge clk); #1;
            spk_ready = 1;
         end
      join
      repeat (3) @(negedge clk);
      check("spk_beats", spk_n, v.exp_beats);
      check("spk_order_data", spk_bad, 0);
      check("stdp_cycles", stdp_n, v.exp_stdp);
      check("stdp_bits", stdp_bad, 0);
      check("fetches", fetch_n, v.exp_fetch);
      check("w_beats", w_n, v.exp_w);
      check("w_order_data", w_bad, 0);
      check("done_pulses", done_n, 1);
      check("done_latency", done_cyc - last_ev, 1);
      check("busy_after", busy, 0);
      if (v.stall) begin
         check("stall_stable", stall_bad, 0);
         check("stall_fetch", stall_fetch, 0);
      end
      wtog = 0;
   endtask

   initial begin
      vec_t vecs [5];
      vecs[0] = '{T: 3, learn: 0, wt: 0, stall: 0, exp_beats: 3, exp_stdp: 0,        exp_fetch: 3, exp_w: 0};
      vecs[1] = '{T: 0, learn: 0, wt: 0, stall: 0, exp_beats: 0, exp_stdp: 0,        exp_fetch: 0, exp_w: 0};
      vecs[2] = '{T: 3, learn: 0, wt: 0, stall: 1, exp_beats: 3, exp_stdp: 0,        exp_fetch: 3, exp_w: 0};
      vecs[3] = '{T: 2, learn: 1, wt: 1, stall: 0, exp_beats: 2, exp_stdp: 2 * TOT,  exp_fetch: 2, exp_w: TOT};
      vecs[4] = '{T: 1, learn: 0, wt: 0, stall: 0, exp_beats: 1, exp_stdp: 0,        exp_fetch: 1, exp_w: 0};

      repeat (4) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("rst_state", dbg_state, S_IDLE);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_strobes", {ev_rd_en, stdp_enable, spk_valid, w_valid}, 4'b0);
      check("rst_event_vec", event_vec, 0);
      check("rst_addrs", {rb_addr, ev_addr}, 0);
      check("rst_pre_post", {stdp_pre_bits, stdp_post_bits}, 0);

      for (int i = 0; i < 4; i++) run(vecs[i]);

      // Reset in the middle of the STDP scan
      pulse_start(1, 1);
      begin
         bit seen = 0;
         for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (stdp_enable) seen = 1;
         end
         check("learn_reached", seen, 1);
      end
      repeat (100) @(negedge clk);
      rst = 1;
      @(posedge clk); #1;
      check("midrst_stdp", stdp_enable, 0);
      check("midrst_busy", busy, 0);
      check("midrst_state", dbg_state, S_IDLE);
      @(negedge clk);
      rst = 0;
      repeat (3) @(negedge clk);
      check("midrst_no_done", done_n, 0);

      run(vecs[4]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/snn_step_sequencer.md
Name: snn_step_sequencer

Overview:
- Synthesizable timestep controller for snn_core. Replaces the software-driven step/learn/dump loop.
- Fetches one F-bit event row per timestep from an event RAM, presents it to the core and captures the N-bit spike row one cycle later.
- Streams captured spike rows out through a valid/ready port.
- Optionally runs one full STDP scan per step, then streams all F*N learned weights out through the core's readback port.

Parameters:
- F, 48, input features (event row width)
- N, 96, neurons (spike row width)
- AW, $clog2(F*N), weight/readback address width
- EW, 16, event-RAM address width (max 2^EW timesteps)
- SCAN, F*N, STDP scan length in clocks per step

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle run request; accepted only in IDLE
- cfg_T  in  EW+1  timesteps to run; sampled at accepted start
- cfg_learn  in  1  enable STDP scan and final weight dump; sampled at accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of run
- ev_rd_en  out  1  event-RAM read strobe
- ev_addr  out  EW  event-RAM address
- ev_rdata  in  F  event row; valid exactly 1 cycle after ev_rd_en
- event_vec  out  F  row to core
- spikes_vec  in  N  core spike row
- stdp_enable  out  1  to core
- stdp_pre_bits  out  F  to core
- stdp_post_bits  out  N  to core
- spk_valid  out  1  spike-row stream valid
- spk_ready  in  1  spike-row stream ready
- spk_data  out  N  captured spike row
- spk_t  out  EW  timestep index of spk_data
- rb_addr  out  AW  core readback address
- rb_data  in  16  core readback data, 1-cycle latency
- w_valid  out  1  weight-dump stream valid
- w_ready  in  1  weight-dump stream ready
- w_addr  out  AW  weight index
- w_data  out  16  weight (two's complement)

Behaviour:
- Reset (rst=1 at posedge): state IDLE.
  - All outputs 0: busy, done, ev_rd_en, stdp_enable, spk_valid, w_valid, event_vec, pre/post bits, rb_addr, ev_addr.
  - Reset mid-run abandons the run immediately; stdp_enable drops the same edge; no done pulse.
- FSM: IDLE -> FETCH -> LOAD -> EVAL -> EMIT -> [LEARN -> GAP] -> FETCH/… -> [DUMP] -> FIN -> IDLE.
- IDLE: on start, latch cfg_T and cfg_learn; t=0; busy=1.
  - cfg_T=0 -> FIN directly: no reads, no spikes; done one cycle after start.
- FETCH: ev_rd_en=1, ev_addr=t (1 cycle).
- LOAD: event_vec <= ev_rdata. event_vec holds stable until the next LOAD.
- EVAL: one clock for the core to evaluate.
- EMIT:
  - Capture spikes_vec into spk_data and t into spk_t at the first EMIT cycle; spikes are thus sampled exactly 2 edges after event_vec updates.
  - spk_valid=1; hold data stable until spk_valid&&spk_ready.
  - Backpressure stalls the FSM; event_vec is held and the captured row is not overwritten.
- LEARN (learn only): stdp_pre_bits=event_vec, stdp_post_bits=captured row, stdp_enable=1 for exactly SCAN consecutive cycles (scan counter 0..SCAN-1).
- GAP: stdp_enable=0 for 1 cycle.
- After EMIT (no learn) or GAP: t++. Go to FETCH if t<T_latched, else DUMP (learn) or FIN.
- DUMP: stream addresses 0..F*N-1 in order.
  - rb_addr drives the index; w_data = rb_data registered 1 cycle later; w_addr = matching index.
  - Hold on !w_ready with no skipped or duplicated words.
  - Leave after the last handshake (index F*N-1).
- FIN: done=1 for 1 cycle, busy=0 on the following cycle; return to IDLE.
- start while busy is ignored. cfg changes mid-run have no effect.
- t counter is EW+1 bits; T_latched up to 2^EW is legal with no wrap; ev_addr uses t[EW-1:0].

Optional Feature:
- Macro SNN_SEQ_SPKCNT_EN.
- Defined: adds outputs spk_total (32b) and spk_max_row (log2(N)+1 bits).
  - Both clear at accepted start.
  - At each EMIT capture, spk_total += popcount(row) and spk_max_row = max(prior, popcount).
  - Both hold after done until the next start.
- Undefined: ports absent, no popcount logic.

Decomposition:
- Package snn_seq_pkg: state enum seq_state_t, localparams F/N/AW defaults, function popcount_n.
- Sub-module snn_seq_dump: readback-to-stream converter covering the DUMP address counter, 1-cycle data alignment and ready stall. The main FSM hands it a go pulse and waits for its fin.

Test Plan:
- cfg_T=3, learn=0, RAM rows 0x1,0x2,0x4, spk_ready=1 -> 3 spk beats, spk_t=0,1,2; no stdp_enable; done 1 cycle after 3rd handshake.
- cfg_T=2, learn=1 -> stdp_enable high exactly 4608 cycles per step, pre_bits equal row; w_valid beats 4608 with w_addr 0..4607 matching core weights.
- spk_ready low for 10 cycles at t=1 -> spk_data/spk_t stable, event_vec unchanged, no extra fetch; resumes in order.
- w_ready toggling 1,0,0,1 during DUMP -> every address 0..4607 appears exactly once, in order.
- cfg_T=0 -> done asserted, no ev_rd_en, no spk_valid. start pulsed while busy -> ignored.
- rst asserted mid-LEARN -> next cycle stdp_enable=0, busy=0, IDLE; a fresh start with cfg_T=1 completes normally.
